// File: rtl/score_engine_pkg.sv
// ============================================================================
// Module      : score_pkg
// Description : Shared defaults, feedback codes and FSM encoding for the
//               Mastermind score engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    localparam int C_SLOTS_DEF   = 4;
    localparam int C_COLOR_W_DEF = 3;

    localparam logic [1:0] FB_NONE    = 2'd0;
    localparam logic [1:0] FB_PARTIAL = 2'd1;
    localparam logic [1:0] FB_EXACT   = 2'd2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXACT = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_engine_if.sv
// ============================================================================
// Module      : score_engine_if
// Description : Request/result bundle between the guess history and the
//               score engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_engine_if #(
    parameter int SLOTS   = 4,
    parameter int COLOR_W = 3
);
    logic                       start;
    logic                       last_turn;
    logic [SLOTS*COLOR_W-1:0]   guess;
    logic [SLOTS*COLOR_W-1:0]   code;
    logic                       busy;
    logic                       done;
    logic [2:0]                 exact_cnt;
    logic [2:0]                 partial_cnt;
    logic [SLOTS*2-1:0]         fb;
    logic                       win;
    logic                       game_over;

    modport master (
        output start, last_turn, guess, code,
        input  busy, done, exact_cnt, partial_cnt, fb, win, game_over
    );

    modport slave (
        input  start, last_turn, guess, code,
        output busy, done, exact_cnt, partial_cnt, fb, win, game_over
    );
endinterface

`default_nettype wire

// File: rtl/score_engine_color_tally.sv
// ============================================================================
// Module      : color_tally
// Description : Counts the unmasked slots holding a given colour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_tally #(
    parameter int SLOTS   = 4,
    parameter int COLOR_W = 3
) (
    input  wire logic [SLOTS*COLOR_W-1:0] slots_i,
    input  wire logic [SLOTS-1:0]         mask_i,
    input  wire logic [COLOR_W-1:0]       color_i,
    output logic      [2:0]               count_o
);

    always_comb begin
        count_o = 3'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!mask_i[i] && (slots_i[i*COLOR_W +: COLOR_W] == color_i)) begin
                count_o = count_o + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_engine.sv
// ============================================================================
// Module      : score_engine
// Description : Multi-cycle Mastermind scorer: exact pass over slots, then a
//               per-colour partial pass, then registered feedback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_engine
    import score_pkg::*;
#(
    parameter int SLOTS   = C_SLOTS_DEF,
    parameter int COLOR_W = C_COLOR_W_DEF
) (
    input  wire logic    clk,
    input  wire logic    reset,
    score_engine_if.slave bus
);

    localparam int              SLOT_IW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int              VEC_W     = SLOTS * COLOR_W;
    localparam logic [SLOT_IW-1:0] C_LAST_SLOT = SLOT_IW'(SLOTS - 1);

    logic [1:0]         state_q,       state_d;
    logic [SLOT_IW-1:0] slot_q,        slot_d;
    logic [COLOR_W-1:0] color_q,       color_d;
    logic [VEC_W-1:0]   guess_q,       guess_d;
    logic [VEC_W-1:0]   code_q,        code_d;
    logic               last_q,        last_d;
    logic [SLOTS-1:0]   mask_q,        mask_d;
    logic [2:0]         ex_w_q,        ex_w_d;
    logic [2:0]         pa_w_q,        pa_w_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic [2:0]         exact_cnt_q,   exact_cnt_d;
    logic [2:0]         partial_cnt_q, partial_cnt_d;
    logic [SLOTS*2-1:0] fb_q,          fb_d;
    logic               win_q,         win_d;
    logic               game_over_q,   game_over_d;

    logic               w_slot_hit;
    logic [2:0]         w_gc;
    logic [2:0]         w_cc;
    logic               w_win;
    logic [3:0]         w_ex_ext;
    logic [3:0]         w_sum;
    logic [SLOTS*2-1:0] w_fb;

    color_tally #(.SLOTS(SLOTS), .COLOR_W(COLOR_W)) u_tally_guess (
        .slots_i (guess_q),
        .mask_i  (mask_q),
        .color_i (color_q),
        .count_o (w_gc)
    );

    color_tally #(.SLOTS(SLOTS), .COLOR_W(COLOR_W)) u_tally_code (
        .slots_i (code_q),
        .mask_i  (mask_q),
        .color_i (color_q),
        .count_o (w_cc)
    );

    always_comb begin
        w_slot_hit = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if ((slot_q == SLOT_IW'(i)) &&
                (guess_q[i*COLOR_W +: COLOR_W] == code_q[i*COLOR_W +: COLOR_W])) begin
                w_slot_hit = 1'b1;
            end
        end
    end

    assign w_win    = (ex_w_q == 3'(SLOTS));
    assign w_ex_ext = {1'b0, ex_w_q};
    assign w_sum    = {1'b0, ex_w_q} + {1'b0, pa_w_q};

    // Exact pegs fill the low digits first, then partial pegs, then blanks.
    generate
        for (genvar d = 0; d < SLOTS; d++) begin : g_fb
            assign w_fb[d*2 +: 2] = (4'(d) < w_ex_ext) ? FB_EXACT   :
                                    (4'(d) < w_sum)    ? FB_PARTIAL : FB_NONE;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        color_d       = color_q;
        guess_d       = guess_q;
        code_d        = code_q;
        last_d        = last_q;
        mask_d        = mask_q;
        ex_w_d        = ex_w_q;
        pa_w_d        = pa_w_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        exact_cnt_d   = exact_cnt_q;
        partial_cnt_d = partial_cnt_q;
        fb_d          = fb_q;
        win_d         = win_q;
        game_over_d   = game_over_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    guess_d = bus.guess;
                    code_d  = bus.code;
                    last_d  = bus.last_turn;
                    mask_d  = '0;
                    ex_w_d  = 3'd0;
                    pa_w_d  = 3'd0;
                    slot_d  = '0;
                    busy_d  = 1'b1;
                    state_d = EXACT;
                end
            end
            EXACT: begin
                if (w_slot_hit) begin
                    ex_w_d         = ex_w_q + 3'd1;
                    mask_d[slot_q] = 1'b1;
                end
                slot_d = slot_q + 1'b1;
                if (slot_q == C_LAST_SLOT) begin
                    color_d = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                pa_w_d  = pa_w_q + min3(w_gc, w_cc);
                color_d = color_q + 1'b1;
                if (color_q == '1) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                exact_cnt_d   = ex_w_q;
                partial_cnt_d = pa_w_q;
                fb_d          = w_fb;
                win_d         = w_win;
                if (w_win || last_q) begin
                    game_over_d = 1'b1;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            color_q       <= '0;
            guess_q       <= '0;
            code_q        <= '0;
            last_q        <= 1'b0;
            mask_q        <= '0;
            ex_w_q        <= 3'd0;
            pa_w_q        <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            exact_cnt_q   <= 3'd0;
            partial_cnt_q <= 3'd0;
            fb_q          <= '0;
            win_q         <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            color_q       <= color_d;
            guess_q       <= guess_d;
            code_q        <= code_d;
            last_q        <= last_d;
            mask_q        <= mask_d;
            ex_w_q        <= ex_w_d;
            pa_w_q        <= pa_w_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            exact_cnt_q   <= exact_cnt_d;
            partial_cnt_q <= partial_cnt_d;
            fb_q          <= fb_d;
            win_q         <= win_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.exact_cnt   = exact_cnt_q;
    assign bus.partial_cnt = partial_cnt_q;
    assign bus.fb          = fb_q;
    assign bus.win         = win_q;
    assign bus.game_over   = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_score_engine.sv
// ============================================================================
// Module      : tb_score_engine
// Description : Directed bench for score_engine with a cycle-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_engine;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    score_engine_if #(.SLOTS(4), .COLOR_W(3)) bus();

    score_engine #(.SLOTS(4), .COLOR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    logic chk_en = 1'b0;

    // Reference state: what the outputs must show after each edge.
    int         m_cnt  = -1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_ex   = 3'd0;
    logic [2:0] m_pa   = 3'd0;
    logic [7:0] m_fb   = 8'd0;
    logic       m_win  = 1'b0;
    logic       m_go   = 1'b0;
    int         p_ex   = 0;
    int         p_pa   = 0;
    logic       p_lt   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [11:0] pack(input int s0, input int s1, input int s2, input int s3);
        logic [2:0] a, b, c, d;
        a = 3'(s0); b = 3'(s1); c = 3'(s2); d = 3'(s3);
        return {d, c, b, a};
    endfunction

    // Partial = total colour overlap minus exact hits.
    task automatic score(input logic [11:0] g, input logic [11:0] c, output int ex, output int pa);
        int gh[8];
        int ch[8];
        int total;
        ex = 0; total = 0;
        for (int k = 0; k < 8; k++) begin gh[k] = 0; ch[k] = 0; end
        for (int i = 0; i < 4; i++) begin
            if (g[i*3 +: 3] == c[i*3 +: 3]) ex++;
            gh[int'(g[i*3 +: 3])]++;
            ch[int'(c[i*3 +: 3])]++;
        end
        for (int k = 0; k < 8; k++) total += (gh[k] < ch[k]) ? gh[k] : ch[k];
        pa = total - ex;
    endtask

    function automatic logic [7:0] fb_of(input int ex, input int pa);
        logic [7:0] v;
        v = 8'd0;
        for (int d = 0; d < 4; d++) begin
            if (d < ex)           v[d*2 +: 2] = 2'd2;
            else if (d < ex + pa) v[d*2 +: 2] = 2'd1;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = -1; m_busy = 0; m_done = 0; m_ex = 0; m_pa = 0;
            m_fb = 0; m_win = 0; m_go = 0;
        end else begin
            m_done = 0;
            if (m_cnt >= 0) begin
                m_cnt++;
                if (m_cnt == 13) begin
                    m_ex   = 3'(p_ex);
                    m_pa   = 3'(p_pa);
                    m_fb   = fb_of(p_ex, p_pa);
                    m_win  = (p_ex == 4);
                    m_go   = m_go | m_win | p_lt;
                    m_done = 1;
                    m_busy = 0;
                    m_cnt  = -1;
                end
            end else if (bus.start) begin
                score(bus.guess, bus.code, p_ex, p_pa);
                p_lt   = bus.last_turn;
                m_cnt  = 0;
                m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",        32'(bus.busy),        32'(m_busy));
            check("done",        32'(bus.done),        32'(m_done));
            check("exact_cnt",   32'(bus.exact_cnt),   32'(m_ex));
            check("partial_cnt", 32'(bus.partial_cnt), 32'(m_pa));
            check("fb",          32'(bus.fb),          32'(m_fb));
            check("win",         32'(bus.win),         32'(m_win));
            check("game_over",   32'(bus.game_over),   32'(m_go));
            if (bus.done === 1'b1) n_done++;
        end
    end

    task automatic do_start(input logic [11:0] g, input logic [11:0] c, input logic lt);
        @(negedge clk);
        bus.guess = g; bus.code = c; bus.last_turn = lt; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.last_turn = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            n_checks++;
            $display("FAIL wait_done: no done pulse within 40 cycles, required one");
        end
    endtask

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic check_result(input string t, input int ex, input int pa,
                                input logic [7:0] fb, input logic w, input logic go);
        check({t, "_exact"},   32'(bus.exact_cnt),   32'(ex));
        check({t, "_partial"}, 32'(bus.partial_cnt), 32'(pa));
        check({t, "_fb"},      32'(bus.fb),          32'(fb));
        check({t, "_win"},     32'(bus.win),         32'(w));
        check({t, "_go"},      32'(bus.game_over),   32'(go));
    endtask

    initial begin
        int lat;
        int d0;
        bus.start = 0; bus.last_turn = 0; bus.guess = '0; bus.code = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check_result("reset", 0, 0, 8'h00, 1'b0, 1'b0);

        do_start(pack(1,2,3,4), pack(1,2,3,4), 1'b0);
        wait_done(lat);
        check("t1_latency", 32'(lat), 32'd13);
        check_result("t1", 4, 0, 8'hAA, 1'b1, 1'b1);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(bus.done), 32'd0);

        apply_reset();
        do_start(pack(4,3,2,1), pack(1,2,3,4), 1'b0);
        wait_done(lat);
        check_result("t2", 0, 4, 8'h55, 1'b0, 1'b0);

        do_start(pack(5,1,5,5), pack(5,5,1,2), 1'b0);
        wait_done(lat);
        check_result("t3", 1, 2, 8'h16, 1'b0, 1'b0);

        do_start(pack(3,3,3,3), pack(0,0,7,7), 1'b1);
        wait_done(lat);
        check_result("t4", 0, 0, 8'h00, 1'b0, 1'b1);
        do_start(pack(0,0,7,7), pack(0,0,7,7), 1'b0);
        wait_done(lat);
        check_result("t4b", 4, 0, 8'hAA, 1'b1, 1'b1);

        apply_reset();
        d0 = n_done;
        do_start(pack(4,3,2,1), pack(1,2,3,4), 1'b0);
        repeat (3) @(negedge clk);
        bus.guess = pack(1,2,3,4); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check_result("t5", 0, 4, 8'h55, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t5_done_count", 32'(n_done - d0), 32'd1);

        d0 = n_done;
        do_start(pack(1,1,2,2), pack(2,2,1,1), 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check_result("t6", 0, 0, 8'h00, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t6_no_done", 32'(n_done - d0), 32'd0);
        do_start(pack(1,1,2,2), pack(2,2,1,1), 1'b0);
        wait_done(lat);
        check("t6_latency", 32'(lat), 32'd13);
        check_result("t6b", 0, 4, 8'h55, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_engine.md
Name: score_engine

Overview:
- Multi-cycle Mastermind scorer between the guess history and the seven-segment feedback path.
- On a start pulse it captures one submitted guess and the secret code, then counts exact matches (right colour, right slot) and partial matches (right colour, wrong slot).
- Emits per-digit feedback codes, a win flag and a sticky game-over flag.

Parameters:
SLOTS, 4, number of code positions (peg LEDs)
COLOR_W, 3, bits per colour (rgb triplet; all 2^COLOR_W values are valid colours, including 0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; clears all state and outputs
start  in  1  one-cycle pulse; score current guess/code
last_turn  in  1  sampled with start; this guess is the final permitted turn
guess  in  SLOTS*COLOR_W  packed guess, slot 0 in LSBs
code  in  SLOTS*COLOR_W  packed secret code, slot 0 in LSBs
busy  out  1  high while scoring
done  out  1  one-cycle pulse when results update
exact_cnt  out  3  exact matches, 0..SLOTS
partial_cnt  out  3  partial matches, 0..SLOTS
fb  out  SLOTS*2  per-digit feedback codes, digit 0 in LSBs
win  out  1  exact_cnt == SLOTS for last scored guess
game_over  out  1  sticky: set on win or on last_turn completion

Behaviour:
- Synchronous active-high reset:
  - State goes to IDLE.
  - busy, done, exact_cnt, partial_cnt, fb, win and game_over all go to 0.
  - Reset wins over every other input in the same cycle, including mid-score; no done pulse is emitted for an aborted score.
- States: IDLE -> EXACT -> COUNT -> EMIT -> IDLE.
- IDLE:
  - start=1 captures guess, code and last_turn into internal registers and clears the working counters and match mask.
  - Next state is EXACT with slot index 0. busy rises on the next edge.
- EXACT (SLOTS cycles), one slot i per cycle:
  - If guess[i] == code[i], increment the working exact count and set mask[i].
  - After i = SLOTS-1, go to COUNT with colour index 0.
- COUNT (2^COLOR_W cycles), one colour c per cycle:
  - gc = number of unmasked guess slots equal to c.
  - cc = number of unmasked code slots equal to c.
  - Add min(gc, cc) to the working partial count.
  - After c = 2^COLOR_W - 1, go to EMIT.
- EMIT (1 cycle):
  - Registers exact_cnt, partial_cnt, fb and win. done=1 for this cycle only; busy stays high through EMIT.
  - If win or the captured last_turn is set, game_over is set.
  - Returns to IDLE.
- Latency: from the edge sampling start to the edge raising done is SLOTS + 2^COLOR_W + 1 = 13 cycles at defaults. Back-to-back throughput is one score per 14 cycles.
- fb encoding, packed from digit 0 upward:
  - First exact_cnt digits = FB_EXACT (2).
  - Next partial_cnt digits = FB_PARTIAL (1).
  - Remaining digits = FB_NONE (0).
- Invariant: exact_cnt + partial_cnt <= SLOTS. The working adders are 3 bits wide and never wrap.
- start while not in IDLE is ignored. Captured operands stay frozen; changes on guess/code during busy have no effect.
- Outputs other than done hold their last values until the next EMIT.
- game_over is sticky until reset, but further starts are still scored.

Decomposition:
- Package score_pkg holds:
  - SLOTS and COLOR_W defaults.
  - Feedback codes FB_NONE=2'd0, FB_PARTIAL=2'd1, FB_EXACT=2'd2.
  - State encoding IDLE/EXACT/COUNT/EMIT.
- One sub-module, color_tally: combinational; takes the packed slots, the mask and a colour; returns the count of unmasked slots equal to that colour.
  - Instantiated twice, once for guess and once for code.

Test Plan:
- code={1,2,3,4}, guess={1,2,3,4}, start -> after 13 cycles done=1 for one cycle; exact_cnt=4, partial_cnt=0, fb=2,2,2,2, win=1, game_over=1.
- code={1,2,3,4}, guess={4,3,2,1}, start -> exact_cnt=0, partial_cnt=4, fb=1,1,1,1, win=0, game_over=0.
- code={5,5,1,2}, guess={5,1,5,5}, start -> exact_cnt=1, partial_cnt=2, fb=2,1,1,0.
- code={0,0,7,7}, guess={3,3,3,3}, last_turn=1, start -> exact_cnt=0, partial_cnt=0, fb=0,0,0,0, win=0, game_over=1. A second start with a winning guess scores normally and game_over stays 1.
- Second start 4 cycles after the first -> ignored: exactly one done pulse, and the result reflects the first operands. Changing guess mid-score -> no effect on the result.
- reset asserted in cycle 6 of a score -> next cycle busy=0 and all outputs 0; no done pulse. A new start afterwards completes in 13 cycles.
